// File: rtl/inst_fetch_mem_pkg.sv
// Shared constants for the IF-stage instruction memory: bus widths, enable
// encodings and default pipeline shape.
package inst_fetch_mem_pkg;
  localparam int          InstAddrBus      = 32;
  localparam logic [31:0] ZeroWord         = 32'h0000_0000;
  localparam logic        ChipEnable       = 1'b1;
  localparam logic        ChipDisable      = 1'b0;
  localparam int          InstFetchLatency = 2;
  localparam int          InstFetchWidth   = 1;
endpackage

// File: rtl/inst_resp_fifo.sv
// First-word-fall-through response FIFO with synchronous flush and occupancy
// count. Head data reads as zero while empty so idle outputs are quiet.
module inst_resp_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic                        do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Upstream credit accounting guarantees a push never meets a full FIFO
  // unless a pop happens in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_next(wr_ptr);
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/inst_fetch_mem.sv
// Pipelined instruction memory: credit-controlled request intake, multi-lane
// array read, LATENCY-deep valid/data pipe and an FWFT response FIFO.
module inst_fetch_mem
  import inst_fetch_mem_pkg::*;
#(
  parameter int INST_W      = 32,
  parameter int ADDR_W      = InstAddrBus,
  parameter int DEPTH_LOG2  = 10,
  parameter int FETCH_WIDTH = InstFetchWidth,
  parameter int LATENCY     = InstFetchLatency
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic                          flush,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [FETCH_WIDTH*INST_W-1:0] resp_inst,
  output logic [FETCH_WIDTH-1:0]        resp_mask,
  output logic                          resp_fault,
  output logic [ADDR_W-1:0]             resp_addr,
  input  logic                          prog_we,
  input  logic [DEPTH_LOG2-1:0]         prog_addr,
  input  logic [INST_W-1:0]             prog_data
);
  localparam int FIFO_DEPTH = LATENCY + 1;
  localparam int STAGES     = LATENCY - 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int WORDS      = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic [ADDR_W-1:0]                  addr;
    logic                               fault;
    logic [FETCH_WIDTH-1:0]             mask;
    logic [FETCH_WIDTH-1:0][INST_W-1:0] inst;
  } resp_t;

  logic [INST_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // Request decode and lane read. The array is read combinationally in the
  // acceptance cycle, so a same-cycle program write is seen only afterwards.
  logic [DEPTH_LOG2-1:0]              word_idx;
  logic                               fault;
  logic [FETCH_WIDTH-1:0]             lane_ok;
  logic [FETCH_WIDTH-1:0][INST_W-1:0] rd_inst;

  assign word_idx = req_addr[DEPTH_LOG2+1:2];
  assign fault    = (|req_addr[1:0]) || (|req_addr[ADDR_W-1:DEPTH_LOG2+2]);

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane
    logic [DEPTH_LOG2:0] idx;
    assign idx        = {1'b0, word_idx} + (DEPTH_LOG2 + 1)'(k);
    assign lane_ok[k] = !fault && !idx[DEPTH_LOG2];
    assign rd_inst[k] = lane_ok[k] ? mem[idx[DEPTH_LOG2-1:0]] : INST_W'(ZeroWord);
  end

  // Stage 0 is the accepted request itself; stages 1..STAGES are registered.
  logic [STAGES:0] vld_pipe;
  resp_t [STAGES:0] data_pipe;
  logic            acc;

  assign acc          = req_valid && req_ready;
  assign vld_pipe[0]  = acc;
  assign data_pipe[0] = '{addr: req_addr, fault: fault, mask: lane_ok, inst: rd_inst};

  if (STAGES > 0) begin : g_pipe
    logic  [STAGES:1] vld_q;
    resp_t [STAGES:1] data_q;

    always_ff @(posedge clk) begin
      if (rst || flush) vld_q <= '0;
      else              vld_q <= vld_pipe[STAGES-1:0];
      data_q <= data_pipe[STAGES-1:0];
    end

    assign vld_pipe[STAGES:1]  = vld_q;
    assign data_pipe[STAGES:1] = data_q;
  end

  int inflight;
  always_comb begin
    inflight = 0;
    for (int i = 1; i <= STAGES; i++) inflight += int'(vld_pipe[i]);
  end

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  resp_t            head;

  // Every accepted request holds a FIFO slot from acceptance until its pop.
  assign req_ready = !rst && (ce == ChipEnable) && !flush &&
                     ((inflight + int'(fifo_count)) < FIFO_DEPTH);

  inst_resp_fifo #(
    .WIDTH ($bits(resp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (vld_pipe[STAGES] && !flush),
    .push_data (data_pipe[STAGES]),
    .pop       (resp_valid && resp_ready),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign resp_valid = !fifo_empty;
  assign resp_inst  = head.inst;
  assign resp_mask  = head.mask;
  assign resp_fault = head.fault;
  assign resp_addr  = head.addr;
endmodule

// File: tb/tb_inst_fetch_mem.sv
// Randomized + directed bench for inst_fetch_mem against a queue-based model
// of outstanding requests with per-request due times.
module tb_inst_fetch_mem;
  localparam int L  = 2;
  localparam int FW = 2;
  localparam int DL = 4;
  localparam int NW = 1 << DL;
  localparam int FD = L + 1;

  logic clk = 1'b0;
  logic rst, ce, flush, req_valid, resp_ready, prog_we;
  logic [31:0]      req_addr;
  logic [DL-1:0]    prog_addr;
  logic [31:0]      prog_data;
  logic             req_ready, resp_valid, resp_fault;
  logic [FW*32-1:0] resp_inst;
  logic [FW-1:0]    resp_mask;
  logic [31:0]      resp_addr;

  inst_fetch_mem #(
    .INST_W(32), .ADDR_W(32), .DEPTH_LOG2(DL), .FETCH_WIDTH(FW), .LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst),
    .resp_mask(resp_mask), .resp_fault(resp_fault), .resp_addr(resp_addr),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        fault;
    logic [1:0]  mask;
    logic [63:0] inst;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [NW];
  int          edges    = 0;
  bit          rst_q    = 1'b0;
  bit          last_acc = 1'b0;

  function automatic exp_t predict(logic [31:0] a);
    exp_t e;
    e.addr  = a;
    e.inst  = '0;
    e.mask  = '0;
    e.due   = 0;
    e.fault = (a % 4 != 0) || (a >= NW * 4);
    if (!e.fault)
      for (int k = 0; k < FW; k++) begin
        int w;
        w = int'(a / 4) + k;
        if (w < NW) begin
          e.mask[k] = 1'b1;
          e.inst[k*32 +: 32] = ref_mem[w];
        end
      end
    return e;
  endfunction

  // One clock cycle: check outputs, drive inputs, update the model at the edge.
  task automatic step(bit rv, logic [31:0] a, bit rr, bit fl = 0, bit c = 1,
                      bit r = 0, bit we = 0, logic [DL-1:0] pa = '0,
                      logic [31:0] pd = '0);
    bit   exp_vld, exp_rdy, acc, pop;
    exp_t e;
    @(negedge clk);
    exp_vld = (q.size() > 0) && (q[0].due <= edges);
    chk("resp_valid", 64'(resp_valid), 64'(exp_vld));
    if (exp_vld) begin
      chk("resp_inst",  64'(resp_inst),  q[0].inst);
      chk("resp_mask",  64'(resp_mask),  64'(q[0].mask));
      chk("resp_fault", 64'(resp_fault), 64'(q[0].fault));
      chk("resp_addr",  64'(resp_addr),  64'(q[0].addr));
    end
    if (rst_q) begin
      chk("rst_inst",  64'(resp_inst),  64'd0);
      chk("rst_mask",  64'(resp_mask),  64'd0);
      chk("rst_fault", 64'(resp_fault), 64'd0);
      chk("rst_addr",  64'(resp_addr),  64'd0);
    end
    req_valid = rv; req_addr = a; resp_ready = rr; flush = fl; ce = c; rst = r;
    prog_we = we; prog_addr = pa; prog_data = pd;
    #1;
    exp_rdy = !r && c && !fl && (q.size() < FD);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    acc = rv && exp_rdy;
    pop = exp_vld && rr;
    if (acc) begin
      e = predict(a);
      e.due = edges + L;
    end
    @(posedge clk);
    edges++;
    if (fl || r) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (we) ref_mem[pa] = pd;
    rst_q    = r;
    last_acc = acc;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, 1);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; ce = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0;
    resp_ready = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    step(0, '0, 0, 0, 1, 1);
    step(0, '0, 0, 0, 1, 1);

    // Preload words 0..15 with 0x13+k through the program port.
    for (int k = 0; k < NW; k++) step(0, '0, 1, 0, 1, 0, 1, DL'(k), 32'h13 + 32'(k));

    step(1, 32'h8, 1);
    idle(3);
    step(1, 32'h3C, 1);
    step(1, 32'h40, 1);
    idle(3);

    // Backpressure: only FIFO_DEPTH requests fit, then drain in order.
    a = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step(1, a, 0);
      if (last_acc) a += 4;
    end
    chk("bp_accepted", 64'(a), 64'h0C);
    for (int i = 0; i < 5; i++) step(0, '0, 1);

    step(1, 32'h6, 1);
    idle(3);

    // Flush with requests in flight, then a fresh request.
    step(1, 32'h0, 1);
    step(1, 32'h4, 1);
    step(1, 32'h8, 1, 1);
    step(1, 32'h20, 1);
    idle(3);

    // Read-before-write, then reset mid-stream keeps memory.
    step(1, 32'h14, 1, 0, 1, 0, 1, DL'(5), 32'hDEADBEEF);
    idle(3);
    step(1, 32'h14, 1);
    step(1, 32'h18, 1);
    step(0, '0, 1, 0, 1, 1);
    step(1, 32'h14, 1);
    idle(3);
    chk("mem_keep", 64'(ref_mem[5]), 64'hDEADBEEF);

    for (int i = 0; i < 600; i++) begin
      case ($urandom % 8)
        0, 1, 2, 3, 4: a = {26'd0, 4'($urandom), 2'b00};
        5:             a = 32'h3C;
        6:             a = 32'($urandom % 64);
        default:       a = $urandom;
      endcase
      step(($urandom % 4) != 0, a, ($urandom % 3) != 0, ($urandom % 20) == 0,
           ($urandom % 10) != 0, ($urandom % 80) == 0, ($urandom % 5) == 0,
           DL'($urandom), $urandom);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
